iecdrv_head_pos: RTL and testbench

//  Parametrised head-position / media-state controller for IEC drive models (1541 single-sided, 1571 double-sided).

---
 rtl/iecdrv_head_pos_if.sv | 31 +++
 rtl/iecdrv_head_pos.sv | 162 ++++++++++++++++
 tb/tb_iecdrv_head_pos.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iecdrv_head_pos_if.sv
// Drive-side bundle of the head-position controller: stepper/motor/activity
// inputs, position and media-sense outputs, and the save request handshake.
interface iecdrv_head_pos_if;
  logic [1:0] stp;
  logic       mtr;
  logic       act;
  logic       side;
  logic       we;
  logic [6:0] track;
  logic       track_side;
  logic       tr00_sense_n;
  logic       wps_n;
  logic       disk_present;
  logic       save_req;
  logic [6:0] save_track;
  logic       save_side;
  logic       save_ack;
  logic       save_ovf;

  modport master (
    output stp, mtr, act, side, we, save_ack,
    input  track, track_side, tr00_sense_n, wps_n, disk_present,
           save_req, save_track, save_side, save_ovf
  );

  modport slave (
    input  stp, mtr, act, side, we, save_ack,
    output track, track_side, tr00_sense_n, wps_n, disk_present,
           save_req, save_track, save_side, save_ovf
  );
endinterface

// File: rtl/iecdrv_head_pos.sv
// Head position / media state tracker for 1541/1571 drive models, with a
// two-entry queue of dirty-track save requests drained by a req/ack handshake.
module iecdrv_head_pos #(
  parameter int HT_MAX   = 84,
  parameter int HT_RESET = 36,
  parameter int SIDES    = 1,
  parameter int CHG_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic [31:0]      img_size,
  iecdrv_head_pos_if.slave bus
);

  logic [1:0]       r_stp_old;
  logic [6:0]       r_track_num;
  logic [6:0]       r_track;
  logic             r_side;
  logic             r_track_side;
  logic             r_tr00_n;
  logic             r_dirty;
  logic             r_ovf;
  logic             r_readonly;
  logic             r_present;
  logic             r_mnt_old;
  logic [1:0]       r_q_cnt;
  logic [1:0][7:0]  r_q;
  logic [CHG_W-1:0] r_timer;

  logic [1:0]       w_move;
  logic             w_side_in;
  logic             w_up;
  logic             w_dn;
  logic             w_step;
  logic             w_side_evt;
  logic             w_trig;
  logic             w_pop;
  logic             w_mount;
  logic [7:0]       w_entry;
  logic [6:0]       w_track_num_next;
  logic             w_dirty_next;
  logic [1:0][7:0]  w_q_next;
  logic [1:0]       w_q_cnt_next;
  logic             w_ovf_set;

  generate
    if (SIDES == 2) begin : g_two_sides
      assign w_side_in = bus.side;
    end else begin : g_one_side
      assign w_side_in = 1'b0;
    end
  endgenerate

  // Phase difference modulo 4: 01 steps in, 11 steps out, 10/00 ignored.
  assign w_move     = bus.stp - r_stp_old;
  assign w_up       = bus.mtr & (w_move == 2'b01);
  assign w_dn       = bus.mtr & (w_move == 2'b11);
  assign w_step     = w_up | w_dn;
  assign w_side_evt = (w_side_in != r_side);
  assign w_trig     = r_dirty & (w_step | w_side_evt | ~bus.act);
  assign w_pop      = bus.save_ack & (r_q_cnt != 2'd0);
  assign w_mount    = img_mounted & ~r_mnt_old;
  assign w_entry    = {r_track_num, r_side};

  always_comb begin
    w_track_num_next = r_track_num;
    if (w_up && (r_track_num < 7'(HT_MAX))) begin
      w_track_num_next = r_track_num + 7'd1;
    end else if (w_dn && (r_track_num != 7'd0)) begin
      w_track_num_next = r_track_num - 7'd1;
    end
  end

  // A write in the trigger cycle belongs to the new position, so it re-dirties.
  always_comb begin
    w_dirty_next = r_dirty;
    if (w_trig)  w_dirty_next = 1'b0;
    if (bus.we)  w_dirty_next = 1'b1;
    if (w_mount) w_dirty_next = 1'b0;
  end

  always_comb begin
    w_q_next     = r_q;
    w_q_cnt_next = r_q_cnt;
    w_ovf_set    = 1'b0;
    case ({w_trig, w_pop})
      2'b01: begin
        w_q_next[0]  = r_q[1];
        w_q_cnt_next = r_q_cnt - 2'd1;
      end
      2'b10: begin
        if (r_q_cnt == 2'd2) begin
          w_ovf_set = 1'b1;
        end else begin
          w_q_next[r_q_cnt[0]] = w_entry;
          w_q_cnt_next         = r_q_cnt + 2'd1;
        end
      end
      2'b11: begin
        if (r_q_cnt == 2'd2) begin
          w_q_next[0] = r_q[1];
          w_q_next[1] = w_entry;
        end else begin
          w_q_next[0] = w_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stp_old    <= bus.stp;
      r_track_num  <= 7'(HT_RESET);
      r_track      <= 7'(HT_RESET);
      r_side       <= 1'b0;
      r_track_side <= 1'b0;
      r_tr00_n     <= (HT_RESET != 0);
      r_dirty      <= 1'b0;
      r_ovf        <= 1'b0;
      r_readonly   <= 1'b0;
      r_present    <= 1'b0;
      r_mnt_old    <= img_mounted;
      r_q_cnt      <= 2'd0;
      r_q          <= '0;
      r_timer      <= '0;
    end else begin
      r_stp_old    <= bus.stp;
      r_track_num  <= w_track_num_next;
      r_track      <= r_track_num;
      r_side       <= w_side_in;
      r_track_side <= r_side;
      r_tr00_n     <= (r_track_num != 7'd0);
      r_dirty      <= w_dirty_next;
      r_ovf        <= r_ovf | w_ovf_set;
      r_mnt_old    <= img_mounted;
      r_q_cnt      <= w_q_cnt_next;
      r_q          <= w_q_next;
      if (w_mount) begin
        r_timer    <= '1;
        r_readonly <= img_readonly;
        r_present  <= |img_size;
      end else if (ce && (r_timer != '0)) begin
        r_timer    <= r_timer - 1'b1;
      end
    end
  end

  assign bus.track        = r_track;
  assign bus.track_side   = r_track_side;
  assign bus.tr00_sense_n = r_tr00_n;
  assign bus.wps_n        = ~r_readonly ^ r_timer[CHG_W-2];
  assign bus.disk_present = r_present;
  assign bus.save_req     = (r_q_cnt != 2'd0);
  assign bus.save_track   = r_q[0][7:1];
  assign bus.save_side    = r_q[0][0];
  assign bus.save_ovf     = r_ovf;

endmodule

// File: tb/tb_iecdrv_head_pos.sv
// Bench for iecdrv_head_pos: one single-sided and one double-sided instance
// driven in parallel and compared against a behavioural model each cycle.
module tb_iecdrv_head_pos;
  localparam int CHG_W  = 6;
  localparam int HT_MAX = 84;
  localparam int HT_RST = 36;

  logic        clk = 1'b0;
  logic        t_reset = 1'b1;
  logic        t_ce = 1'b0;
  logic        t_mnt = 1'b0;
  logic        t_ro = 1'b0;
  logic [31:0] t_size = 32'd0;
  logic [1:0]  t_stp = 2'd0;
  logic        t_mtr = 1'b0;
  logic        t_act = 1'b1;
  logic        t_side = 1'b0;
  logic        t_we = 1'b0;
  logic        t_ack = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iecdrv_head_pos_if ifa();
  iecdrv_head_pos_if ifb();

  assign ifa.stp = t_stp;   assign ifb.stp = t_stp;
  assign ifa.mtr = t_mtr;   assign ifb.mtr = t_mtr;
  assign ifa.act = t_act;   assign ifb.act = t_act;
  assign ifa.side = t_side; assign ifb.side = t_side;
  assign ifa.we = t_we;     assign ifb.we = t_we;
  assign ifa.save_ack = t_ack; assign ifb.save_ack = t_ack;

  iecdrv_head_pos #(.HT_MAX(HT_MAX), .HT_RESET(HT_RST), .SIDES(1), .CHG_W(CHG_W)) u_dut_a (
    .clk(clk), .reset(t_reset), .ce(t_ce), .img_mounted(t_mnt),
    .img_readonly(t_ro), .img_size(t_size), .bus(ifa));

  iecdrv_head_pos #(.HT_MAX(HT_MAX), .HT_RESET(HT_RST), .SIDES(2), .CHG_W(CHG_W)) u_dut_b (
    .clk(clk), .reset(t_reset), .ce(t_ce), .img_mounted(t_mnt),
    .img_readonly(t_ro), .img_size(t_size), .bus(ifb));

  // Behavioural model, index 0 = single-sided, 1 = double-sided.
  int m_tn[2], m_trk[2], m_sd[2], m_tsd[2], m_tr00[2], m_dirty[2];
  int m_qn[2], m_ovf[2], m_ro[2], m_pres[2], m_timer[2], m_stp_old[2], m_mnt_old[2];
  int m_qt[2][2], m_qs[2][2];

  task automatic model_update(input int k);
    int d, sd_in, e_t, e_s;
    bit step, trig, pop;
    if (t_reset) begin
      m_tn[k] = HT_RST; m_trk[k] = HT_RST; m_sd[k] = 0; m_tsd[k] = 0; m_tr00[k] = 1;
      m_dirty[k] = 0; m_qn[k] = 0; m_ovf[k] = 0; m_ro[k] = 0; m_pres[k] = 0;
      m_timer[k] = 0; m_stp_old[k] = int'(t_stp); m_mnt_old[k] = int'(t_mnt);
    end else begin
      d     = (int'(t_stp) - m_stp_old[k] + 4) % 4;
      step  = t_mtr && (d == 1 || d == 3);
      sd_in = (k == 1) ? int'(t_side) : 0;
      trig  = (m_dirty[k] != 0) && (step || sd_in != m_sd[k] || !t_act);
      e_t   = m_tn[k];
      e_s   = m_sd[k];
      pop   = t_ack && m_qn[k] > 0;
      m_trk[k]  = m_tn[k];
      m_tsd[k]  = m_sd[k];
      m_tr00[k] = (m_tn[k] != 0);
      if (t_mtr && d == 1 && m_tn[k] < HT_MAX) m_tn[k]++;
      else if (t_mtr && d == 3 && m_tn[k] > 0) m_tn[k]--;
      m_sd[k] = sd_in;
      if (trig) m_dirty[k] = 0;
      if (t_we) m_dirty[k] = 1;
      if (t_mnt && m_mnt_old[k] == 0) m_dirty[k] = 0;
      if (pop) begin
        m_qt[k][0] = m_qt[k][1]; m_qs[k][0] = m_qs[k][1]; m_qn[k]--;
      end
      if (trig) begin
        if (m_qn[k] == 2) m_ovf[k] = 1;
        else begin
          m_qt[k][m_qn[k]] = e_t; m_qs[k][m_qn[k]] = e_s; m_qn[k]++;
        end
      end
      if (t_mnt && m_mnt_old[k] == 0) begin
        m_timer[k] = (1 << CHG_W) - 1;
        m_ro[k]    = int'(t_ro);
        m_pres[k]  = (t_size != 0);
      end else if (t_ce && m_timer[k] > 0) begin
        m_timer[k]--;
      end
      m_mnt_old[k] = int'(t_mnt);
      m_stp_old[k] = int'(t_stp);
    end
  endtask

  function automatic logic [20:0] exp_vec(input int k);
    logic req, wps;
    req = (m_qn[k] != 0);
    wps = (m_ro[k] == 0) ^ (((m_timer[k] >> (CHG_W - 2)) & 1) != 0);
    return {7'(m_trk[k]), m_tsd[k] != 0, m_tr00[k] != 0, wps, m_pres[k] != 0, req,
            req ? 7'(m_qt[k][0]) : 7'd0, req ? (m_qs[k][0] != 0) : 1'b0, m_ovf[k] != 0};
  endfunction

  function automatic logic [20:0] obs_vec(input int k);
    if (k == 0)
      return {ifa.track, ifa.track_side, ifa.tr00_sense_n, ifa.wps_n, ifa.disk_present,
              ifa.save_req, ifa.save_req ? ifa.save_track : 7'd0,
              ifa.save_req ? ifa.save_side : 1'b0, ifa.save_ovf};
    return {ifb.track, ifb.track_side, ifb.tr00_sense_n, ifb.wps_n, ifb.disk_present,
            ifb.save_req, ifb.save_req ? ifb.save_track : 7'd0,
            ifb.save_req ? ifb.save_side : 1'b0, ifb.save_ovf};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic test_reset();
    t_reset = 1'b1;
    cyc(); cyc();
    t_reset = 1'b0;
    cyc();
    n_total++;
    if (ifa.track !== 7'd36 || ifa.save_req !== 1'b0 || ifa.wps_n !== 1'b1 ||
        ifa.tr00_sense_n !== 1'b1 || ifa.save_ovf !== 1'b0 || ifa.disk_present !== 1'b0)
      $display("FAIL reset_const got trk=%0d req=%b wps=%b tr00=%b ovf=%b dp=%b exp 36 0 1 1 0 0",
               ifa.track, ifa.save_req, ifa.wps_n, ifa.tr00_sense_n, ifa.save_ovf, ifa.disk_present);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs_vec(k) !== exp_vec(k))
        $display("FAIL reset_model[%0d] got %h exp %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    $display("reset: track=%0d", ifa.track);
  endtask

  task automatic test_step_up();
    t_mtr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      t_stp = 2'(i);
      cyc();
      n_total++;
      if (ifa.track !== 7'(35 + i))
        $display("FAIL step_lat1 got %0d exp %0d", ifa.track, 35 + i);
      else n_pass++;
      cyc();
      n_total++;
      if (ifa.track !== 7'(36 + i) || ifa.tr00_sense_n !== 1'b1)
        $display("FAIL step_up got trk=%0d tr00=%b exp trk=%0d tr00=1", ifa.track, ifa.tr00_sense_n, 36 + i);
      else n_pass++;
      $display("step up: stp=%0d track=%0d", t_stp, ifa.track);
    end
  endtask

  task automatic test_bounds();
    for (int i = 0; i < 100 && m_tn[0] > 1; i++) begin t_stp = t_stp - 2'd1; cyc(); end
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin t_stp = t_stp - 2'd1; cyc(); cyc(); end
    n_total++;
    if (ifa.track !== 7'd0 || ifa.tr00_sense_n !== 1'b0)
      $display("FAIL bound_low got trk=%0d tr00=%b exp 0 0", ifa.track, ifa.tr00_sense_n);
    else n_pass++;
    $display("bound low: track=%0d tr00_n=%b", ifa.track, ifa.tr00_sense_n);
    for (int i = 0; i < 100 && m_tn[0] < HT_MAX; i++) begin t_stp = t_stp + 2'd1; cyc(); end
    t_stp = t_stp + 2'd1; cyc(); cyc(); cyc();
    n_total++;
    if (ifa.track !== 7'd84 || obs_vec(0) !== exp_vec(0))
      $display("FAIL bound_high got %0d exp 84 (vec %h exp %h)", ifa.track, obs_vec(0), exp_vec(0));
    else n_pass++;
    $display("bound high: track=%0d", ifa.track);
  endtask

  task automatic test_save();
    for (int i = 0; i < 100 && m_tn[0] > 40; i++) begin t_stp = t_stp - 2'd1; cyc(); end
    cyc(); cyc();
    t_we = 1'b1; cyc(); t_we = 1'b0;
    t_stp = t_stp + 2'd1; cyc();
    n_total++;
    if (ifa.save_req !== 1'b1 || ifa.save_track !== 7'd40)
      $display("FAIL save_first got req=%b trk=%0d exp 1 40", ifa.save_req, ifa.save_track);
    else n_pass++;
    t_we = 1'b1; cyc(); t_we = 1'b0;
    t_act = 1'b0; cyc(); t_act = 1'b1;
    cyc();
    n_total++;
    if (ifa.save_req !== 1'b1 || ifa.save_track !== 7'd40 || obs_vec(0) !== exp_vec(0))
      $display("FAIL save_hold got req=%b trk=%0d exp 1 40", ifa.save_req, ifa.save_track);
    else n_pass++;
    t_ack = 1'b1; cyc(); t_ack = 1'b0;
    n_total++;
    if (ifa.save_req !== 1'b1 || ifa.save_track !== 7'd41)
      $display("FAIL save_second got req=%b trk=%0d exp 1 41", ifa.save_req, ifa.save_track);
    else n_pass++;
    t_ack = 1'b1; cyc(); t_ack = 1'b0;
    n_total++;
    if (ifa.save_req !== 1'b0)
      $display("FAIL save_drain got req=%b exp 0", ifa.save_req);
    else n_pass++;
    $display("save: queue drained, req=%b", ifa.save_req);
  endtask

  task automatic fill_one();
    t_we = 1'b1; cyc(); t_we = 1'b0;
    t_act = 1'b0; cyc(); t_act = 1'b1;
  endtask

  task automatic test_overflow();
    fill_one();
    t_stp = t_stp + 2'd1; cyc();
    fill_one();
    t_we = 1'b1; cyc(); t_we = 1'b0;
    t_act = 1'b0; t_ack = 1'b1; cyc(); t_act = 1'b1; t_ack = 1'b0;
    n_total++;
    if (ifa.save_ovf !== 1'b0 || ifa.save_req !== 1'b1 || ifa.save_track !== 7'd42)
      $display("FAIL ovf_simul got ovf=%b req=%b trk=%0d exp 0 1 42", ifa.save_ovf, ifa.save_req, ifa.save_track);
    else n_pass++;
    t_stp = t_stp + 2'd1; cyc();
    fill_one();
    n_total++;
    if (ifa.save_ovf !== 1'b1 || ifa.save_track !== 7'd42 || obs_vec(0) !== exp_vec(0))
      $display("FAIL ovf_full got ovf=%b trk=%0d exp 1 42", ifa.save_ovf, ifa.save_track);
    else n_pass++;
    t_ack = 1'b1; cyc(); cyc(); t_ack = 1'b0;
    n_total++;
    if (ifa.save_req !== 1'b0 || ifa.save_ovf !== 1'b1)
      $display("FAIL ovf_drain got req=%b ovf=%b exp 0 1", ifa.save_req, ifa.save_ovf);
    else n_pass++;
    $display("overflow: ovf=%b", ifa.save_ovf);
  endtask

  task automatic test_mount();
    int toggles;
    logic prev;
    t_ro = 1'b1; t_size = 32'd174848; t_ce = 1'b1;
    t_mnt = 1'b1; cyc(); t_mnt = 1'b0;
    n_total++;
    if (ifa.disk_present !== 1'b1)
      $display("FAIL mount_present got %b exp 1", ifa.disk_present);
    else n_pass++;
    toggles = 0;
    prev = ifa.wps_n;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (ifa.wps_n !== prev) toggles++;
      prev = ifa.wps_n;
      n_total++;
      if (obs_vec(0) !== exp_vec(0))
        $display("FAIL mount_model got %h exp %h", obs_vec(0), exp_vec(0));
      else n_pass++;
    end
    n_total++;
    if (toggles < 2 || ifa.wps_n !== 1'b0)
      $display("FAIL mount_wps got toggles=%0d wps=%b exp >=2 0", toggles, ifa.wps_n);
    else n_pass++;
    t_size = 32'd0; t_mnt = 1'b1; cyc(); t_mnt = 1'b0; cyc();
    n_total++;
    if (ifa.disk_present !== 1'b0)
      $display("FAIL mount_empty got %b exp 0", ifa.disk_present);
    else n_pass++;
    $display("mount: toggles=%0d wps_n=%b present=%b", toggles, ifa.wps_n, ifa.disk_present);
  endtask

  task automatic test_side();
    t_reset = 1'b1; t_side = 1'b0; cyc(); cyc(); t_reset = 1'b0; cyc();
    t_we = 1'b1; cyc(); t_we = 1'b0;
    t_side = 1'b1; cyc();
    n_total++;
    if (ifb.save_req !== 1'b1 || ifb.save_side !== 1'b0 || ifb.save_track !== 7'd36 || ifa.save_req !== 1'b0)
      $display("FAIL side_req got B req=%b sd=%b trk=%0d A req=%b exp 1 0 36 0",
               ifb.save_req, ifb.save_side, ifb.save_track, ifa.save_req);
    else n_pass++;
    cyc();
    n_total++;
    if (ifb.track_side !== 1'b1 || ifa.track_side !== 1'b0)
      $display("FAIL side_track got B=%b A=%b exp 1 0", ifb.track_side, ifa.track_side);
    else n_pass++;
    t_reset = 1'b1; cyc(); t_reset = 1'b0;
    n_total++;
    if (ifb.save_req !== 1'b0 || ifb.track !== 7'd36)
      $display("FAIL side_reset got req=%b trk=%0d exp 0 36", ifb.save_req, ifb.track);
    else n_pass++;
    $display("side: B track_side reset, req=%b track=%0d", ifb.save_req, ifb.track);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      t_reset = ($urandom_range(0, 149) == 0);
      t_ce    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) t_mnt = ~t_mnt;
      t_ro    = 1'($urandom_range(0, 1));
      t_size  = ($urandom_range(0, 1) != 0) ? 32'd174848 : 32'd0;
      t_stp   = 2'($urandom_range(0, 3));
      t_mtr   = ($urandom_range(0, 3) != 0);
      t_act   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) t_side = ~t_side;
      t_we    = ($urandom_range(0, 3) == 0);
      t_ack   = ($urandom_range(0, 2) == 0);
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL random[%0d] cyc %0d got %h exp %h", k, i, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    $display("random: 600 cycles done");
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_bounds();
    test_save();
    test_overflow();
    test_mount();
    test_side();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
